// File: rtl/axi4_imem_rd_slave.sv
// AXI4 read-only slave streaming FIXED/INCR/WRAP instruction bursts from an on-chip word memory.
// Define IMEM_WRAP_BURST_EN to build WRAP sequencing; without it WRAP bursts answer SLVERR.
module axi4_imem_rd_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [7:0]                     S_AXI_ARLEN,
  input  logic [2:0]                     S_AXI_ARSIZE,
  input  logic [1:0]                     S_AXI_ARBURST,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RLAST,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]          prog_wdata,
  output logic                           busy
);

  localparam int unsigned      IdxW       = $clog2(DEPTH_WORDS);
  localparam int unsigned      WordW      = ADDR_WIDTH - 2;
  localparam logic [WordW-1:0] DepthWords = WordW'(DEPTH_WORDS);
  localparam logic [WordW-1:0] WordOne    = WordW'(1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_e          state_q;
  logic            arready_q;
  logic            busy_q;
  logic [WordW-1:0] w_q;
  logic [7:0]      cnt_q;
  logic [1:0]      burst_q;
  logic            err_q;
`ifdef IMEM_WRAP_BURST_EN
  logic [3:0]      wrap_mask_q;
`endif

  // Head entry drives the R channel; skid entry holds the read that was in flight at a stall.
  logic                  rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  sk_valid_q, sk_last_q;
  logic [DATA_WIDTH-1:0] sk_data_q;
  logic [1:0]            sk_resp_q;

  logic [WordW-1:0]      ar_word;
  logic                  ar_err;
  logic [WordW-1:0]      w_next;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            beat_resp;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_last;
  logic                  ar_hs;
  logic                  issue;
  logic                  pop;

  assign ar_word   = WordW'((S_AXI_ARADDR - BASE_ADDR) >> 2);
  assign ar_hs     = S_AXI_ARVALID && arready_q;
  assign issue     = (state_q == StBurst) && !sk_valid_q;
  assign pop       = rvalid_q && S_AXI_RREADY;
  // An address below BASE_ADDR wraps to a huge word index and so also lands out of range.
  assign in_range  = (w_q < DepthWords);
  assign mem_rdata = mem[w_q[IdxW-1:0]];
  assign beat_last = (cnt_q == 8'd0);

  always_comb begin
    ar_err = (S_AXI_ARSIZE != 3'b010);
    case (S_AXI_ARBURST)
      BurstFixed, BurstIncr: ;
`ifdef IMEM_WRAP_BURST_EN
      BurstWrap: begin
        if (!(S_AXI_ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_err = 1'b1;
      end
`endif
      // Reserved burst type, and WRAP when not built, are refused for the whole burst.
      default: ar_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next = w_q;
    case (burst_q)
      BurstIncr: w_next = w_q + WordOne;
`ifdef IMEM_WRAP_BURST_EN
      BurstWrap: begin
        w_next = (w_q & ~{{(WordW-4){1'b0}}, wrap_mask_q})
               | ((w_q + WordOne) & {{(WordW-4){1'b0}}, wrap_mask_q});
      end
`endif
      default: w_next = w_q;
    endcase
  end

  always_comb begin
    if (err_q) begin
      beat_resp = RespSlverr;
    end else if (in_range) begin
      beat_resp = RespOkay;
    end else begin
      beat_resp = RespDecerr;
    end
    beat_data = (beat_resp == RespOkay) ? mem_rdata : '0;
  end

  // Nonblocking write: a read of the same word on the same edge captures the old contents.
  always_ff @(posedge aclk) begin
    if (prog_we) mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      arready_q   <= 1'b0;
      busy_q      <= 1'b0;
      w_q         <= '0;
      cnt_q       <= '0;
      burst_q     <= BurstFixed;
      err_q       <= 1'b0;
`ifdef IMEM_WRAP_BURST_EN
      wrap_mask_q <= '0;
`endif
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
      rlast_q     <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_resp_q   <= RespOkay;
      sk_last_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            state_q     <= StBurst;
            arready_q   <= 1'b0;
            busy_q      <= 1'b1;
            w_q         <= ar_word;
            cnt_q       <= S_AXI_ARLEN;
            burst_q     <= S_AXI_ARBURST;
            err_q       <= ar_err;
`ifdef IMEM_WRAP_BURST_EN
            wrap_mask_q <= S_AXI_ARLEN[3:0];
`endif
          end else begin
            arready_q <= 1'b1;
          end
        end
        StBurst: begin
          if (issue) begin
            w_q   <= w_next;
            cnt_q <= cnt_q - 8'd1;
            if (beat_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && rlast_q) begin
            state_q   <= StIdle;
            arready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (!rvalid_q || pop) begin
        if (sk_valid_q) begin
          rvalid_q   <= 1'b1;
          rdata_q    <= sk_data_q;
          rresp_q    <= sk_resp_q;
          rlast_q    <= sk_last_q;
          sk_valid_q <= 1'b0;
        end else if (issue) begin
          rvalid_q <= 1'b1;
          rdata_q  <= beat_data;
          rresp_q  <= beat_resp;
          rlast_q  <= beat_last;
        end else begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
        end
      end else if (issue) begin
        sk_valid_q <= 1'b1;
        sk_data_q  <= beat_data;
        sk_resp_q  <= beat_resp;
        sk_last_q  <= beat_last;
      end
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axi4_imem_rd_slave.sv
// Bench for axi4_imem_rd_slave: vector table, reset corner case and randomized bursts vs a model.
module tb_axi4_imem_rd_slave;

  localparam int unsigned Depth = 16;
`ifdef IMEM_WRAP_BURST_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        busy;

  always #5 aclk = ~aclk;

  axi4_imem_rd_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(Depth),
    .BASE_ADDR  (32'h0)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARLEN  (arlen),
    .S_AXI_ARSIZE (arsize),
    .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RLAST  (rlast),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [Depth];
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];
  int          exp_n;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          mode;   // 0: RREADY held high, 1: RREADY pattern 1,0,0,1
    logic [31:0] fd;
    logic [1:0]  fr;
    logic [31:0] ld;
    logic [1:0]  lr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = 4'(idx);
    prog_wdata = d;
    ref_mem[idx] = d;
    @(negedge aclk);
    prog_we = 1'b0;
  endtask

  // Expected beats from burst rules: beat i visits word w0, w0+i, or the wrap window around w0.
  task automatic model(input logic [31:0] addr, input int len, input logic [2:0] size,
                       input logic [1:0] burst);
    int n, w0, wb, w;
    bit err;
    n   = len + 1;
    err = (size != 3'd2) || (burst == 2'b11) ||
          (burst == 2'b10 && !(WrapEn && (n == 2 || n == 4 || n == 8 || n == 16)));
    w0  = int'(addr >> 2);
    wb  = (w0 / n) * n;
    exp_n = n;
    for (int i = 0; i < n; i++) begin
      case (burst)
        2'b00:   w = w0;
        2'b01:   w = w0 + i;
        default: w = wb + (w0 - wb + i) % n;
      endcase
      if (err) begin
        exp_d[i] = '0;
        exp_r[i] = 2'b10;
      end else if (w < int'(Depth)) begin
        exp_d[i] = ref_mem[w];
        exp_r[i] = 2'b00;
      end else begin
        exp_d[i] = '0;
        exp_r[i] = 2'b11;
      end
    end
  endtask

  task automatic send_ar(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit ok);
    int cyc = 0;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    while (arready !== 1'b1 && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    ok = (arready === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_ar_timeout: arready low for %0d cycles, expected a handshake", tag, cyc);
    end else begin
      @(negedge aclk);
      check($sformatf("%s_busy_on", tag), busy, 1'b1);
    end
    arvalid = 1'b0;
  endtask

  task automatic recv(input string tag, input int mode, input int stop_at, output int got,
                      output logic [31:0] f_d, output logic [1:0] f_r,
                      output logic [31:0] l_d, output logic [1:0] l_r);
    int          cyc = 0;
    int          lat = 1;
    bit          stalled = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] h_d = '0;
    logic [1:0]  h_r = '0;
    logic        h_l = 1'b0;
    got = 0;
    f_d = '0; f_r = '0; l_d = '0; l_r = '0;
    while (got < stop_at && cyc < 400) begin
      if (stalled) begin
        check($sformatf("%s_stall_b%0d", tag, got), {rvalid, rlast, rresp, rdata},
              {1'b1, h_l, h_r, h_d});
      end
      if (rvalid === 1'b1 && !seen) begin
        seen = 1'b1;
        if (mode == 0) check($sformatf("%s_latency", tag), lat, 2);
      end
      rready  = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      stalled = 1'b0;
      if (rvalid === 1'b1 && rready) begin
        check($sformatf("%s_beat%0d", tag, got), {rlast, rresp, rdata},
              {1'(got == exp_n - 1), exp_r[got], exp_d[got]});
        if (got == 0) begin
          f_d = rdata;
          f_r = rresp;
        end
        l_d = rdata;
        l_r = rresp;
        got++;
      end else if (rvalid === 1'b1) begin
        stalled = 1'b1;
        h_d = rdata;
        h_r = rresp;
        h_l = rlast;
      end
      @(negedge aclk);
      cyc++;
      lat++;
    end
    if (got < stop_at) begin
      checks++;
      failures++;
      $display("FAIL %s_r_timeout: got %0d beats, expected %0d", tag, got, stop_at);
    end
  endtask

  task automatic run_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           output logic [31:0] f_d, output logic [1:0] f_r,
                           output logic [31:0] l_d, output logic [1:0] l_r);
    bit ok;
    int got;
    f_d = '0; f_r = '0; l_d = '0; l_r = '0;
    model(addr, int'(len), size, burst);
    send_ar(tag, addr, len, size, burst, ok);
    if (ok) begin
      recv(tag, mode, exp_n, got, f_d, f_r, l_d, l_r);
      rready = 1'b0;
      check($sformatf("%s_end", tag), {arready, busy, rvalid}, 3'b100);
    end
  endtask

  initial begin
    logic [31:0] f_d, l_d;
    logic [1:0]  f_r, l_r;
    int          got;
    bit          ok;

    aresetn = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;

    vecs[0] = '{32'h00, 8'd15, 3'd2, 2'b01, 0, 32'h1000, 2'b00, 32'h100F, 2'b00};
    vecs[1] = '{32'h00, 8'd15, 3'd2, 2'b01, 1, 32'h1000, 2'b00, 32'h100F, 2'b00};
`ifdef IMEM_WRAP_BURST_EN
    vecs[2] = '{32'h18, 8'd7,  3'd2, 2'b10, 0, 32'h1006, 2'b00, 32'h1005, 2'b00};
    vecs[6] = '{32'h3C, 8'd15, 3'd2, 2'b10, 1, 32'h100F, 2'b00, 32'h100E, 2'b00};
`else
    vecs[2] = '{32'h18, 8'd7,  3'd2, 2'b10, 0, 32'h0,    2'b10, 32'h0,    2'b10};
    vecs[6] = '{32'h3C, 8'd15, 3'd2, 2'b10, 1, 32'h0,    2'b10, 32'h0,    2'b10};
`endif
    vecs[3] = '{32'h38, 8'd3,  3'd2, 2'b01, 0, 32'h100E, 2'b00, 32'h0,    2'b11};
    vecs[4] = '{32'h00, 8'd1,  3'd1, 2'b01, 0, 32'h0,    2'b10, 32'h0,    2'b10};
    vecs[5] = '{32'h08, 8'd3,  3'd2, 2'b00, 1, 32'h1002, 2'b00, 32'h1002, 2'b00};
    vecs[7] = '{32'h08, 8'd2,  3'd2, 2'b10, 0, 32'h0,    2'b10, 32'h0,    2'b10};
    vecs[8] = '{32'h00, 8'd0,  3'd2, 2'b01, 0, 32'h1000, 2'b00, 32'h1000, 2'b00};
    vecs[9] = '{32'h40, 8'd1,  3'd2, 2'b00, 0, 32'h0,    2'b11, 32'h0,    2'b11};

    #1;
    check("reset_outputs", {arready, rvalid, rlast, rresp, rdata, busy}, '0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    check("arready_before_edge", arready, 1'b0);
    @(negedge aclk);
    check("arready_after_edge", arready, 1'b1);

    for (int i = 0; i < int'(Depth); i++) wr(i, 32'h1000 + i);

    for (int v = 0; v < 10; v++) begin
      run_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                vecs[v].mode, f_d, f_r, l_d, l_r);
      check($sformatf("vec%0d_first", v), {f_r, f_d}, {vecs[v].fr, vecs[v].fd});
      check($sformatf("vec%0d_last", v), {l_r, l_d}, {vecs[v].lr, vecs[v].ld});
    end

    // Reset while beat 5 of a 16-beat burst is on the bus.
    model(32'h0, 15, 3'd2, 2'b01);
    send_ar("rst", 32'h0, 8'd15, 3'd2, 2'b01, ok);
    if (ok) recv("rst", 0, 5, got, f_d, f_r, l_d, l_r);
    aresetn = 1'b0;
    #1;
    check("rst_outputs_now", {arready, rvalid, rlast, rresp, rdata, busy}, '0);
    rready = 1'b0;
    @(negedge aclk);
    check("rst_arready_held", arready, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_arready_back", arready, 1'b1);
    run_burst("post_rst", 32'h10, 8'd0, 3'd2, 2'b01, 0, f_d, f_r, l_d, l_r);
    check("post_rst_beat", {f_r, f_d}, {2'b00, 32'h1004});

    for (int i = 0; i < int'(Depth); i++) wr(i, $urandom);
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  b;
      logic [2:0]  s;
      logic [7:0]  l;
      logic [31:0] a;
      b = 2'($urandom_range(0, 2));
      s = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      if (b == 2'b10) begin
        case ($urandom_range(0, 4))
          0: l = 8'd1;
          1: l = 8'd3;
          2: l = 8'd7;
          3: l = 8'd15;
          default: l = 8'd5;
        endcase
      end else begin
        l = 8'($urandom_range(0, 20));
      end
      a = 32'($urandom_range(0, 22)) << 2;
      run_burst($sformatf("rnd%0d", t), a, l, s, b, int'($urandom_range(0, 1)),
                f_d, f_r, l_d, l_r);
      if ($urandom_range(0, 2) == 0) wr(int'($urandom_range(0, Depth - 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
